mux_arbiter_8x1_4b: RTL
=======================

MUX_ARBITER_8X1_4B -- requirements
Module: mux_arbiter_8x1_4b

Interface
REQ-001 Parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles a requester keeps while others wait; the legal range is 1..15.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request lines; bit k asserted means requester k wants the shared bus.
REQ-005 i0..i7  input  4 each  requester data; ik belongs to req[k].
REQ-006 gnt  output  8  one-hot registered grant, or all-zero.
REQ-007 s  output  3  registered binary index of the granted requester (mux select).
REQ-008 out  output  4  registered shared-bus data.
REQ-009 valid  output  1  registered; asserted when out carries granted data.

Function
REQ-010 The block SHALL have two states: IDLE (gnt=0) and BUSY (gnt one-hot, gnt[s]=1).
REQ-011 Arbitration SHALL be round-robin: search starts at index (last+1) mod 8 and wraps; last is the most recently granted index, and last is 7 after reset so requester 0 wins first.
REQ-012 IDLE: if req!=0 at edge t, the winner SHALL be granted from t+1 (gnt, s updated), BUSY entered, and hold count set to 1; if req==0, stay IDLE.
REQ-013 BUSY, req[s]=1, count<MAX_HOLD: keep the grant and increment count.
REQ-014 BUSY, req[s]=1, count==MAX_HOLD, another req bit set: re-arbitrate excluding s, and the new grant SHALL take effect at t+1 with no idle cycle.
REQ-015 BUSY, req[s]=1, count==MAX_HOLD, no other req: keep the grant and reset count to 1.
REQ-016 BUSY, req[s]=0: if other requests are pending, re-arbitrate with the new grant at t+1; otherwise go to IDLE with gnt=0 at t+1, and s SHALL hold its last value.
REQ-017 Each grant change SHALL update last to the new index.
REQ-018 The data path SHALL be: out(t+1)=i[s](t) and valid(t+1)=1 iff the state is BUSY and req[s]=1 at t; otherwise valid(t+1)=0 and out SHALL hold its value.
REQ-019 Latency SHALL be request at edge t, gnt at t+1, first valid data at t+2.
REQ-020 At most one gnt bit SHALL ever be set, and gnt[k] SHALL never be set in a cycle after req[k] was sampled low.
REQ-021 The hold count SHALL be 4 bits and saturate logic SHALL not wrap past MAX_HOLD.

Reset
REQ-022 rst_n=0 SHALL immediately force gnt=0, s=0, out=0, valid=0, state IDLE, count=0, and last=7, independent of clk.
REQ-023 Reset deasserted mid-transfer SHALL restart arbitration from IDLE with no stale grant and no valid pulse in the first cycle after release.
REQ-024 Reset release SHALL be treated as synchronous to clk by the environment; the block SHALL require no reset synchronizer.

Verification
REQ-025 After reset, req=8'h01, i0=4'hA: expect gnt=8'h01 and s=0 one cycle later, then out=4'hA and valid=1 one cycle after that.
REQ-026 req=8'hFF held, MAX_HOLD=4: expect grants 0,1,2,...,7,0 each lasting 4 cycles, with no gap cycles and gnt always one-hot.
REQ-027 Only req[5] held for 10 cycles: expect gnt=8'h20 continuously, valid=1 from cycle 2 onward, and no gap at the count rollover.
REQ-028 Granted requester 3 drops req while req[6] is pending: expect gnt=8'h40 on the next edge and valid=0 for exactly one cycle.
REQ-029 rst_n pulsed low mid-BUSY: expect gnt, s, out, and valid to be 0 immediately, then after release with req=8'h80, expect requester 7 granted, not index last+1.
REQ-030 req=8'h00 after a grant: expect IDLE, gnt=0, valid=0, and out held at its last value.

Source files
------------

// File: rtl/mux_arbiter_8x1_4b.sv
// 8-requester round-robin arbiter with a 4-bit shared-bus data mux and bounded grant tenure.
// Latency: request sampled at edge t, grant visible after t+1, first valid data after t+2.
// No backpressure: requesters hold req until served; a grant is kept at most MAX_HOLD cycles under contention.
module mux_arbiter_8x1_4b #(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..15; the hold counter is 4 bits wide
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [3:0] i0,
  input  logic [3:0] i1,
  input  logic [3:0] i2,
  input  logic [3:0] i3,
  input  logic [3:0] i4,
  input  logic [3:0] i5,
  input  logic [3:0] i6,
  input  logic [3:0] i7,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic [3:0] out,
  output logic       valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state;
  logic [3:0] count;
  logic [2:0] last;

  logic [3:0] din [8];
  logic [7:0] cand;
  logic [2:0] pick;
  logic       pick_vld;
  logic       own_req;

  assign din[0] = i0;
  assign din[1] = i1;
  assign din[2] = i2;
  assign din[3] = i3;
  assign din[4] = i4;
  assign din[5] = i5;
  assign din[6] = i6;
  assign din[7] = i7;

  assign own_req = req[s];

  // Round-robin search starting one past the last winner; while busy the current owner is excluded
  // so a hand-off always goes to somebody else.
  always_comb begin
    cand     = (state == BUSY) ? (req & ~(8'b1 << s)) : req;
    pick     = last;
    pick_vld = 1'b0;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int off = 8; off >= 1; off--) begin
      if (cand[last + 3'(off)]) begin
        pick     = last + 3'(off);
        pick_vld = 1'b1;
      end
    end
  end

  // Arbitration state, grant/select registers and registered data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 8'h00;
      s     <= 3'd0;
      out   <= 4'h0;
      valid <= 1'b0;
      count <= 4'd0;
      last  <= 3'd7;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          if (pick_vld) begin
            state <= BUSY;
            gnt   <= 8'b1 << pick;
            s     <= pick;
            last  <= pick;
            count <= 4'd1;
          end
        end
        BUSY: begin
          // Data moves only while the owner still asserts its request; otherwise out holds.
          if (own_req) begin
            out   <= din[s];
            valid <= 1'b1;
          end else begin
            valid <= 1'b0;
          end

          if (own_req && (count < HOLD_MAX)) begin
            count <= count + 4'd1;
          end else if (pick_vld) begin
            // Tenure expired with contention, or owner dropped with others pending: direct hand-off.
            gnt   <= 8'b1 << pick;
            s     <= pick;
            last  <= pick;
            count <= 4'd1;
          end else if (own_req) begin
            // Tenure expired but nobody else wants the bus: restart the tenure window.
            count <= 4'd1;
          end else begin
            // Nobody is requesting: release the bus, s keeps pointing at the previous owner.
            state <= IDLE;
            gnt   <= 8'h00;
            count <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
          valid <= 1'b0;
          count <= 4'd0;
        end
      endcase
    end
  end

endmodule
